// File: rtl/bw_pkg.sv
// Shared types, sizes and saturating arithmetic for the bandwidth credit scheduler.
// Requester count and field widths are fixed here and used by every file of the block.
package bw_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned LENW = 4;
  localparam int unsigned IDW  = $clog2(NREQ);
  // One spare code above NREQ-1 so out-of-range config ids are expressible and rejected.
  localparam int unsigned CIDW = $clog2(NREQ + 1);

  localparam logic [CW-1:0] RST_ALLOC0 = CW'(100);
  localparam logic [CW-1:0] RST_ALLOC  = CW'(50);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap
  } state_e;

  typedef struct packed {
    logic [CW-1:0]  balance;
    logic [CW-1:0]  alloc;
    logic [IDW-1:0] id;
  } account_t;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] a);
    return (a == '0) ? a : a - 1'b1;
  endfunction

  // min(bal + alloc, 2*alloc, 2^CW-1), all intermediate terms in CW+1 bits.
  function automatic logic [CW-1:0] sat_refill(input logic [CW-1:0] bal,
                                               input logic [CW-1:0] alloc);
    logic [CW:0] sum;
    logic [CW:0] cap;
    sum = {1'b0, bal} + {1'b0, alloc};
    cap = {alloc, 1'b0};
    if (sum > cap) sum = cap;
    if (sum > {1'b0, {CW{1'b1}}}) sum = {1'b0, {CW{1'b1}}};
    return sum[CW-1:0];
  endfunction

endpackage

// File: rtl/bw_credit_sched_if.sv
// Requester/datapath/config bundle of the credit scheduler.
// master = requesters, datapath and software side; slave = the scheduler.
interface bw_credit_sched_if;
  import bw_pkg::*;

  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic                 beat_done;
  logic                 cfg_we;
  logic [CIDW-1:0]      cfg_id;
  logic [CW-1:0]        cfg_alloc;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 epoch_pulse;

  modport master (
    output req, req_len, beat_done, cfg_we, cfg_id, cfg_alloc,
    input  grant, grant_id, busy, epoch_pulse
  );

  modport slave (
    input  req, req_len, beat_done, cfg_we, cfg_id, cfg_alloc,
    output grant, grant_id, busy, epoch_pulse
  );

endinterface

// File: rtl/bw_winner_sel.sv
// Combinational winner pick: highest-balance eligible requester (ties to lowest id),
// falling back to round-robin over raw requests when nobody holds credit.
module bw_winner_sel
  import bw_pkg::*;
(
  input  logic [CW-1:0]   balance_i [NREQ],
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [IDW-1:0]  winner_o,
  output logic            valid_o,
  output logic            fallback_o
);

  localparam int unsigned Leaves = 1 << IDW;

  // Heap-ordered tree: node k has children 2k and 2k+1, leaves at Leaves..2*Leaves-1.
  logic           node_vld [2*Leaves];
  logic [CW-1:0]  node_bal [2*Leaves];
  logic [IDW-1:0] node_id  [2*Leaves];

  logic           rr_found;
  logic [IDW-1:0] rr_id;

  always_comb begin
    for (int k = 0; k < 2 * Leaves; k++) begin
      node_vld[k] = 1'b0;
      node_bal[k] = '0;
      node_id[k]  = '0;
    end
    for (int i = 0; i < Leaves; i++) begin
      if (i < NREQ) begin
        node_vld[Leaves+i] = req_i[i] && (balance_i[i] != '0);
        node_bal[Leaves+i] = balance_i[i];
      end
      node_id[Leaves+i] = IDW'(i);
    end
    // Left child always covers lower ids, so >= gives the lowest-id tie-break.
    for (int k = Leaves - 1; k >= 1; k--) begin
      if (node_vld[2*k] && (!node_vld[2*k+1] || node_bal[2*k] >= node_bal[2*k+1])) begin
        node_vld[k] = node_vld[2*k];
        node_bal[k] = node_bal[2*k];
        node_id[k]  = node_id[2*k];
      end else begin
        node_vld[k] = node_vld[2*k+1];
        node_bal[k] = node_bal[2*k+1];
        node_id[k]  = node_id[2*k+1];
      end
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!rr_found && req_i[(int'(rr_ptr_i) + j) % NREQ]) begin
        rr_found = 1'b1;
        rr_id    = IDW'((int'(rr_ptr_i) + j) % NREQ);
      end
    end
  end

  assign valid_o    = node_vld[1] || rr_found;
  assign fallback_o = !node_vld[1] && rr_found;
  assign winner_o   = node_vld[1] ? node_id[1] : rr_id;

endmodule

// File: rtl/bw_credit_sched.sv
// Credit-based burst scheduler: per-requester credit accounts refilled each epoch,
// whole-burst grants, one credit debited per accepted beat.
module bw_credit_sched
  import bw_pkg::*;
#(
  parameter int unsigned   EPOCH      = 256,
  parameter logic [CW-1:0] DEF_ALLOC0 = RST_ALLOC0,
  parameter logic [CW-1:0] DEF_ALLOC  = RST_ALLOC
) (
  input logic              clk,
  input logic              reset,
  bw_credit_sched_if.slave bus
);

  localparam int unsigned        EpochW    = $clog2(EPOCH);
  localparam logic [EpochW-1:0] EpochLast = EpochW'(EPOCH - 1);

  state_e              state_q;
  logic [EpochW-1:0]   epoch_cnt_q;
  logic [IDW-1:0]      rr_q;
  logic [LENW-1:0]     beat_cnt_q;
  logic [NREQ-1:0]     grant_q;
  logic [IDW-1:0]      grant_id_q;
  logic                busy_q;
  logic                epoch_pulse_q;
  account_t            acct_q [NREQ];
  account_t            acct_d [NREQ];

  logic [CW-1:0]       bal [NREQ];
  logic [IDW-1:0]      sel_winner;
  logic                sel_valid;
  logic                sel_fallback;
  logic [LENW-1:0]     sel_len;
  logic                refill_now;
  logic                debit;

  assign refill_now = (epoch_cnt_q == EpochLast);
  assign debit      = (state_q == StXfer) && bus.beat_done;

  always_comb begin
    for (int i = 0; i < NREQ; i++) bal[i] = acct_q[i].balance;
  end

  bw_winner_sel u_sel (
    .balance_i  (bal),
    .req_i      (bus.req),
    .rr_ptr_i   (rr_q),
    .winner_o   (sel_winner),
    .valid_o    (sel_valid),
    .fallback_o (sel_fallback)
  );

  always_comb begin
    sel_len = bus.req_len[sel_winner*LENW +: LENW];
    if (sel_len == '0) sel_len = LENW'(1);
  end

  // Debit first, then refill against the pre-write allocation.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      acct_d[i] = acct_q[i];
      if (debit && (acct_q[i].id == grant_id_q)) begin
        acct_d[i].balance = sat_dec(acct_q[i].balance);
      end
      if (refill_now) begin
        acct_d[i].balance = sat_refill(acct_d[i].balance, acct_q[i].alloc);
      end
      if (bus.cfg_we && (bus.cfg_id == CIDW'(acct_q[i].id))) begin
        acct_d[i].alloc = bus.cfg_alloc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        acct_q[i].balance <= (i == 0) ? DEF_ALLOC0 : DEF_ALLOC;
        acct_q[i].alloc   <= (i == 0) ? DEF_ALLOC0 : DEF_ALLOC;
        acct_q[i].id      <= IDW'(i);
      end
    end else begin
      acct_q <= acct_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      epoch_cnt_q   <= '0;
      epoch_pulse_q <= 1'b0;
      rr_q          <= '0;
      beat_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      epoch_pulse_q <= refill_now;
      epoch_cnt_q   <= refill_now ? '0 : epoch_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            grant_q    <= NREQ'(1) << sel_winner;
            grant_id_q <= sel_winner;
            busy_q     <= 1'b1;
            beat_cnt_q <= sel_len;
            state_q    <= StXfer;
            if (sel_fallback) rr_q <= IDW'((int'(sel_winner) + 1) % NREQ);
          end
        end
        StXfer: begin
          if (bus.beat_done) begin
            beat_cnt_q <= beat_cnt_q - 1'b1;
            if (beat_cnt_q == LENW'(1)) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= StGap;
            end
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.epoch_pulse = epoch_pulse_q;

endmodule

// File: tb/tb_bw_credit_sched.sv
// Directed bench for bw_credit_sched: arbitration order, burst timing, saturation,
// epoch refill, config timing and mid-burst reset, with hand-computed expectations.
module tb_bw_credit_sched;
  import bw_pkg::*;

  localparam int unsigned EPOCH = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bw_credit_sched_if bus ();

  bw_credit_sched #(
    .EPOCH      (EPOCH),
    .DEF_ALLOC0 (16'd100),
    .DEF_ALLOC  (16'd50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.req       = '0;
    bus.req_len   = '0;
    bus.beat_done = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_id    = '0;
    bus.cfg_alloc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic tick_to(input int n);
    for (int i = 0; i < 200 && cyc < n; i++) tick();
  endtask

  task automatic wait_busy(input string tag, input logic v);
    for (int i = 0; i < 40 && bus.busy !== v; i++) tick();
    check(tag, 32'(bus.busy), 32'(v));
  endtask

  function automatic logic [31:0] bal(input int i);
    return 32'(dut.acct_q[i].balance);
  endfunction

  initial begin
    // Reset state and highest-balance selection with exact burst timing.
    do_reset();
    check("rst grant", 32'(bus.grant), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst grant_id", 32'(bus.grant_id), 0);
    check("rst epoch_pulse", 32'(bus.epoch_pulse), 0);
    check("rst state", 32'(dut.state_q), 32'(StIdle));
    check("rst epoch_cnt", 32'(dut.epoch_cnt_q), 0);
    check("rst rr", 32'(dut.rr_q), 0);
    check("rst beat_cnt", 32'(dut.beat_cnt_q), 0);
    check("rst bal0", bal(0), 100);
    check("rst bal1", bal(1), 50);
    check("rst bal3", bal(3), 50);

    bus.req     = 4'b0011;
    bus.req_len = 16'h0044;
    tick();
    check("t1 grant", 32'(bus.grant), 32'h1);
    check("t1 busy", 32'(bus.busy), 1);
    check("t1 beat_cnt", 32'(dut.beat_cnt_q), 4);
    bus.beat_done = 1'b1;
    repeat (3) tick();
    check("t1 held", 32'(bus.grant), 32'h1);
    tick();
    check("t1 end busy", 32'(bus.busy), 0);
    check("t1 end grant", 32'(bus.grant), 0);
    check("t1 gap state", 32'(dut.state_q), 32'(StGap));
    check("t1 bal0 mid", bal(0), 96);
    tick();
    check("t1 idle grant", 32'(bus.grant), 0);
    check("t1 idle state", 32'(dut.state_q), 32'(StIdle));
    tick();
    check("t1 regrant", 32'(bus.grant), 32'h1);
    check("t1 regrant id", 32'(bus.grant_id), 0);
    repeat (4) tick();
    check("t1 done busy", 32'(bus.busy), 0);
    check("t1 bal0", bal(0), 92);
    check("t1 bal1", bal(1), 50);

    // Equal balances: lowest id wins, then the undebited ones; len 0 acts as 1.
    do_reset();
    bus.req       = 4'b1110;
    bus.req_len   = 16'h0111;
    bus.beat_done = 1'b1;
    tick();
    check("t2 first", 32'(bus.grant), 32'h2);
    tick();
    check("t2 bal1", bal(1), 49);
    check("t2 end", 32'(bus.busy), 0);
    tick_to(4);
    check("t2 second", 32'(bus.grant), 32'h4);
    tick_to(7);
    check("t2 third", 32'(bus.grant), 32'h8);
    check("t2 third id", 32'(bus.grant_id), 3);
    tick();
    check("t2 len0 end", 32'(bus.busy), 0);
    check("t2 bal3", bal(3), 49);
    tick_to(10);
    check("t2 fourth", 32'(bus.grant), 32'h2);

    // Exhaustion, saturation at zero, then round-robin fallback.
    do_reset();
    bus.cfg_we    = 1'b1;
    bus.cfg_id    = 3'd0;
    bus.cfg_alloc = 16'd0;
    tick();
    bus.cfg_id    = 3'd1;
    bus.cfg_alloc = 16'd2;
    tick();
    bus.cfg_we = 1'b0;
    tick_to(32);
    check("t3 pulse", 32'(bus.epoch_pulse), 1);
    check("t3 bal0 refill", bal(0), 0);
    check("t3 bal1 refill", bal(1), 4);
    bus.req       = 4'b0010;
    bus.req_len   = 16'h0023;
    bus.beat_done = 1'b1;
    wait_busy("t3 pre busy", 1'b1);
    check("t3 pre id", 32'(bus.grant_id), 1);
    wait_busy("t3 pre idle", 1'b0);
    check("t3 bal1 two", bal(1), 2);
    bus.req     = 4'b0011;
    bus.req_len = 16'h0033;
    wait_busy("t3 credit busy", 1'b1);
    check("t3 credit id", 32'(bus.grant_id), 1);
    check("t3 rr kept", 32'(dut.rr_q), 0);
    wait_busy("t3 credit idle", 1'b0);
    check("t3 bal1 sat", bal(1), 0);
    wait_busy("t3 rr1 busy", 1'b1);
    check("t3 rr1 id", 32'(bus.grant_id), 0);
    check("t3 rr1 ptr", 32'(dut.rr_q), 1);
    wait_busy("t3 rr1 idle", 1'b0);
    wait_busy("t3 rr2 busy", 1'b1);
    check("t3 rr2 id", 32'(bus.grant_id), 1);
    check("t3 rr2 ptr", 32'(dut.rr_q), 2);
    wait_busy("t3 rr2 idle", 1'b0);
    wait_busy("t3 rr3 busy", 1'b1);
    check("t3 rr3 id", 32'(bus.grant_id), 0);
    check("t3 rr3 ptr", 32'(dut.rr_q), 1);
    bus.req = '0;
    for (int i = 0; i < 64 && bus.epoch_pulse !== 1'b1; i++) tick();
    check("t3 pulse2", 32'(bus.epoch_pulse), 1);
    check("t3 bal1 after", bal(1), 2);
    check("t3 bal0 after", bal(0), 0);

    // Refill with same-cycle debit, 2*alloc cap, config write on the refill cycle.
    do_reset();
    bus.cfg_we    = 1'b1;
    bus.cfg_id    = 3'd2;
    bus.cfg_alloc = 16'd10;
    tick();
    bus.cfg_we = 1'b0;
    tick_to(31);
    check("t4 no pulse", 32'(bus.epoch_pulse), 0);
    tick();
    check("t4 pulse", 32'(bus.epoch_pulse), 1);
    check("t4 bal2 cap", bal(2), 20);
    check("t4 bal0 cap", bal(0), 200);
    check("t4 bal3", bal(3), 100);
    bus.req     = 4'b0100;
    bus.req_len = 16'h0D00;
    tick();
    check("t4 grant", 32'(bus.grant), 32'h4);
    bus.beat_done = 1'b1;
    repeat (13) tick();
    check("t4 drain busy", 32'(bus.busy), 0);
    check("t4 bal2 drain", bal(2), 7);
    bus.beat_done = 1'b0;
    bus.req_len   = 16'h0200;
    tick_to(48);
    check("t4 regrant", 32'(bus.grant), 32'h4);
    bus.req = '0;
    tick_to(63);
    bus.beat_done = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_id    = 3'd3;
    bus.cfg_alloc = 16'd5;
    tick();
    check("t4 pulse2", 32'(bus.epoch_pulse), 1);
    check("t4 bal2 debit+refill", bal(2), 16);
    check("t4 bal3 old alloc", bal(3), 100);
    check("t4 still busy", 32'(bus.busy), 1);
    bus.cfg_id    = 3'd4;
    bus.cfg_alloc = 16'd0;
    tick();
    bus.cfg_we    = 1'b0;
    bus.beat_done = 1'b0;
    check("t4 burst end", 32'(bus.busy), 0);
    check("t4 alloc3", 32'(dut.acct_q[3].alloc), 5);
    tick_to(96);
    check("t4 bal2 capped", bal(2), 20);
    check("t4 bal3 new alloc", bal(3), 10);
    check("t4 bal0 id4 ignored", bal(0), 200);
    check("t4 bal1", bal(1), 100);

    // Reset in the middle of a burst.
    do_reset();
    bus.req     = 4'b0001;
    bus.req_len = 16'h0008;
    tick();
    check("t6 grant", 32'(bus.grant), 32'h1);
    bus.beat_done = 1'b1;
    tick();
    tick();
    check("t6 bal0 mid", bal(0), 98);
    check("t6 beat_cnt", 32'(dut.beat_cnt_q), 6);
    reset = 1'b1;
    tick();
    check("t6 grant", 32'(bus.grant), 0);
    check("t6 busy", 32'(bus.busy), 0);
    check("t6 state", 32'(dut.state_q), 32'(StIdle));
    check("t6 bal0", bal(0), 100);
    check("t6 bal1", bal(1), 50);
    check("t6 bal2", bal(2), 50);
    check("t6 bal3", bal(3), 50);
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
    check("t6 post bal0", bal(0), 100);
    check("t6 post busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
